// File: rtl/i2c_init_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_pkg                                                   |
// | Brief    : Shared types and constants for the I2C init sequencer.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package i2c_pkg;

  // Table entry layout: {SubAddrH, SubAddrL, Data}
  localparam int c_entry_w = 24;

  // Default 8-bit device write address
  localparam logic [7:0] c_dev_addr_def = 8'h78;

  // Sequencer state encodings
  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_load = 3'd1;
  localparam logic [2:0] c_st_req  = 3'd2;
  localparam logic [2:0] c_st_wait = 3'd3;
  localparam logic [2:0] c_st_err  = 3'd4;
  localparam logic [2:0] c_st_gap  = 3'd5;
  localparam logic [2:0] c_st_done = 3'd6;
  localparam logic [2:0] c_st_fail = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = c_st_idle,
    S_LOAD = c_st_load,
    S_REQ  = c_st_req,
    S_WAIT = c_st_wait,
    S_ERR  = c_st_err,
    S_GAP  = c_st_gap,
    S_DONE = c_st_done,
    S_FAIL = c_st_fail
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_init_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_init_seq_if                                           |
// | Brief    : Request/bus signals between init sequencer and I2C master.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface i2c_init_seq_if;
  logic       write;
  logic [7:0] Addr;
  logic [7:0] SubAddrH;
  logic [7:0] SubAddrL;
  logic [7:0] Data;
  logic       ready;
  logic       errory;

  // Requester side (the init sequencer)
  modport master (
    output write, Addr, SubAddrH, SubAddrL, Data,
    input  ready, errory
  );

  // Responder side (the I2C write master)
  modport slave (
    input  write, Addr, SubAddrH, SubAddrL, Data,
    output ready, errory
  );
endinterface
`default_nettype wire

// File: rtl/i2c_init_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_init_rom                                              |
// | Brief    : Combinational register-init table, {SubAddrH,L,Data}.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module i2c_init_rom
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  wire logic [7:0]           idx,
  output logic      [c_entry_w-1:0] entry
);

  localparam logic [8:0] c_num_regs = 9'(NUM_REGS);

  // Table lookup; anything past the configured length reads as zero
  always_comb begin
    entry = '0;
    if ({1'b0, idx} < c_num_regs) begin
      case (idx)
        8'd0:    entry = 24'h30_08_82;
        8'd1:    entry = 24'h31_03_03;
        8'd2:    entry = 24'h30_17_FF;
        8'd3:    entry = 24'h30_18_FF;
        8'd4:    entry = 24'h30_34_1A;
        8'd5:    entry = 24'h30_35_11;
        8'd6:    entry = 24'h30_36_46;
        8'd7:    entry = 24'h30_37_13;
        8'd8:    entry = 24'h31_08_01;
        8'd9:    entry = 24'h36_30_36;
        8'd10:   entry = 24'h36_31_0E;
        8'd11:   entry = 24'h36_32_E2;
        8'd12:   entry = 24'h36_33_12;
        8'd13:   entry = 24'h36_21_E0;
        8'd14:   entry = 24'h37_04_A0;
        8'd15:   entry = 24'h37_03_5A;
        default: entry = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_init_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_init_seq                                              |
// | Brief    : Power-up register-init sequencer driving an I2C write     |
// |            master: walks the init table, retries NACKed writes and   |
// |            reports done/fail.                                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter int         NUM_REGS   = 16,
  parameter logic [7:0] DEV_ADDR   = c_dev_addr_def,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 64,
  parameter int         TIMEOUT    = 4096
) (
  input  wire logic       I2C_clk,
  input  wire logic       reset,
  input  wire logic       start,
  i2c_init_seq_if.master  bus,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [7:0]      reg_idx
);

  localparam int               c_tmo_w     = $clog2(TIMEOUT) + 1;
  localparam int               c_gap_w     = $clog2(GAP_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_gap_w-1:0] c_gap_lim = c_gap_w'(GAP_CYCLES - 1);
  localparam logic [7:0]       c_last_idx  = 8'(NUM_REGS - 1);
  localparam logic [7:0]       c_max_retry = 8'(MAX_RETRY);

  seq_state_t          r_state, w_state;
  logic                r_start_q, w_start_q;
  logic                r_write, w_write;
  logic [7:0]          r_sub_h, w_sub_h;
  logic [7:0]          r_sub_l, w_sub_l;
  logic [7:0]          r_data, w_data;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_fail, w_fail;
  logic [7:0]          r_idx, w_idx;
  logic [7:0]          r_retry, w_retry;
  logic [c_gap_w-1:0]  r_gap, w_gap;
  logic [c_tmo_w-1:0]  r_tmo, w_tmo;
  logic                r_err, w_err;       // last attempt must be re-sent
  logic                r_tmo_hit, w_tmo_hit; // attempt ended by timeout
  logic                w_launch;
  logic                w_tmo_exp;
  logic [c_entry_w-1:0] w_rom;

  i2c_init_rom #(.NUM_REGS(NUM_REGS)) u_rom (
    .idx   (r_idx),
    .entry (w_rom)
  );

  assign bus.write    = r_write;
  assign bus.Addr     = DEV_ADDR;
  assign bus.SubAddrH = r_sub_h;
  assign bus.SubAddrL = r_sub_l;
  assign bus.Data     = r_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign fail         = r_fail;
  assign reg_idx      = r_idx;

  assign w_launch  = start & ~r_start_q;
  assign w_tmo_exp = (r_tmo >= c_tmo_lim);

  // State and datapath registers; async reset drops write immediately
  always_ff @(posedge I2C_clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_write   <= 1'b0;
      r_sub_h   <= '0;
      r_sub_l   <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_idx     <= '0;
      r_retry   <= '0;
      r_gap     <= '0;
      r_tmo     <= '0;
      r_err     <= 1'b0;
      r_tmo_hit <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_start_q <= w_start_q;
      r_write   <= w_write;
      r_sub_h   <= w_sub_h;
      r_sub_l   <= w_sub_l;
      r_data    <= w_data;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_fail    <= w_fail;
      r_idx     <= w_idx;
      r_retry   <= w_retry;
      r_gap     <= w_gap;
      r_tmo     <= w_tmo;
      r_err     <= w_err;
      r_tmo_hit <= w_tmo_hit;
    end
  end

  // Next-state and next-output logic for the sequencer
  always_comb begin
    w_state   = r_state;
    w_start_q = start;
    w_write   = r_write;
    w_sub_h   = r_sub_h;
    w_sub_l   = r_sub_l;
    w_data    = r_data;
    w_busy    = r_busy;
    w_done    = r_done;
    w_fail    = r_fail;
    w_idx     = r_idx;
    w_retry   = r_retry;
    w_gap     = r_gap;
    w_err     = r_err;
    w_tmo_hit = r_tmo_hit;
    // Free-running saturating counter; cleared whenever REQ/WAIT is entered
    w_tmo     = (r_tmo == '1) ? r_tmo : r_tmo + c_tmo_w'(1);

    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (w_launch) begin
          w_done    = 1'b0;
          w_fail    = 1'b0;
          w_busy    = 1'b1;
          w_idx     = '0;
          w_retry   = '0;
          w_err     = 1'b0;
          w_tmo_hit = 1'b0;
          w_state   = S_LOAD;
        end
      end

      S_LOAD: begin
        {w_sub_h, w_sub_l, w_data} = w_rom;
        w_tmo   = '0;
        w_state = S_REQ;
      end

      S_REQ: begin
        if (w_tmo_exp) begin
          w_write   = 1'b0;
          w_tmo_hit = 1'b1;
          w_state   = S_ERR;
        end else if (!r_write) begin
          // Only raise the request once the master reports idle
          if (bus.ready) begin
            w_write = 1'b1;
          end
        end else if (!bus.ready) begin
          w_write = 1'b0;
          w_tmo   = '0;
          w_state = S_WAIT;
        end
      end

      S_WAIT: begin
        if (w_tmo_exp) begin
          w_tmo_hit = 1'b1;
          w_state   = S_ERR;
        end else if (bus.ready) begin
          w_gap = '0;
          if (bus.errory) begin
            w_state = S_ERR;
          end else begin
            w_err   = 1'b0;
            w_state = S_GAP;
          end
        end
      end

      S_ERR: begin
        // A hung master is not retried: timeout fails the entry outright
        if (r_tmo_hit || (r_retry >= c_max_retry)) begin
          w_busy  = 1'b0;
          w_fail  = 1'b1;
          w_state = S_FAIL;
        end else begin
          w_retry = r_retry + 8'd1;
          w_err   = 1'b1;
          w_gap   = '0;
          w_state = S_GAP;
        end
      end

      S_GAP: begin
        if (r_gap == c_gap_lim) begin
          if (r_err) begin
            w_err   = 1'b0;
            w_tmo   = '0;
            w_state = S_REQ;
          end else if (r_idx == c_last_idx) begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_DONE;
          end else begin
            w_idx   = r_idx + 8'd1;
            w_retry = '0;
            w_state = S_LOAD;
          end
        end else begin
          w_gap = r_gap + c_gap_w'(1);
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_i2c_init_seq                                           |
// | Brief    : Self-checking bench for i2c_init_seq with an I2C master   |
// |            model and a transaction-level reference.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_i2c_init_seq;
  import i2c_pkg::*;

  localparam int NREG = 4;
  localparam int GAP  = 64;
  localparam int TMO  = 4096;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, fail;
  logic [7:0] reg_idx;

  i2c_init_seq_if bus ();

  i2c_init_seq #(
    .NUM_REGS   (NREG),
    .DEV_ADDR   (8'h78),
    .MAX_RETRY  (MAXR),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .I2C_clk (clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .fail    (fail),
    .reg_idx (reg_idx)
  );

  always #5 clk = ~clk;

  // Expected init table, first NREG entries
  logic [23:0] tbl [NREG] = '{24'h300882, 24'h310303, 24'h3017FF, 24'h3018FF};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction log filled by the master model
  typedef struct {
    logic [23:0] ent;
    logic [7:0]  idx;
    int          t_acc;
    int          t_ret;
  } xact_t;

  xact_t xq[$];
  xact_t m_tmp;
  int    cyc = 0;
  int    err_cnt [NREG];  // number of leading NACKed attempts per entry
  bit    never_drop = 1'b0;
  bit    never_return = 1'b0;
  int    m_st, m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_att(input logic [7:0] id);
    int n = 0;
    foreach (xq[i]) if (xq[i].idx == id) n++;
    return n;
  endfunction

  // I2C master model: accepts write, drops ready 2 cycles later, returns after 40
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ready  <= 1'b1;
      bus.errory <= 1'b0;
      m_st       <= 0;
      m_cnt      <= 0;
    end else begin
      case (m_st)
        0: if (bus.write && bus.ready && !never_drop) begin
             m_tmp.ent   = {bus.SubAddrH, bus.SubAddrL, bus.Data};
             m_tmp.idx   = reg_idx;
             m_tmp.t_acc = cyc;
             m_tmp.t_ret = -1;
             xq.push_back(m_tmp);
             m_st <= 1;
           end
        1: begin
             bus.ready <= 1'b0;
             m_cnt     <= 0;
             m_st      <= 2;
           end
        default: if (!never_return) begin
             if (m_cnt == 38) begin
               bus.ready  <= 1'b1;
               bus.errory <= (n_att(xq[$].idx) <= err_cnt[xq[$].idx]);
               xq[$].t_ret = cyc;
               m_st <= 0;
             end else begin
               m_cnt <= m_cnt + 1;
             end
           end
      endcase
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int limit);
    int k = 0;
    while (!(done || fail) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq({nm, ":finished"}, 32'(k < limit), 32'd1);
  endtask

  // Run one sequence and compare against the transaction-level expectation
  task automatic run_seq(input string nm);
    int exp_idx[$];
    bit f_exp = 1'b0;
    int f_idx = 0;
    int n;
    int sz;
    for (int e = 0; e < NREG; e++) begin
      n = (err_cnt[e] > MAXR) ? MAXR + 1 : err_cnt[e] + 1;
      repeat (n) exp_idx.push_back(e);
      if (err_cnt[e] > MAXR) begin
        f_exp = 1'b1;
        f_idx = e;
        break;
      end
    end
    xq.delete();
    pulse_start();
    wait_end(nm, 5000);
    check_eq({nm, ":done"},    32'(done),    32'(!f_exp));
    check_eq({nm, ":fail"},    32'(fail),    32'(f_exp));
    check_eq({nm, ":busy"},    32'(busy),    32'd0);
    check_eq({nm, ":write"},   32'(bus.write), 32'd0);
    check_eq({nm, ":reg_idx"}, 32'(reg_idx), f_exp ? 32'(f_idx) : 32'(NREG - 1));
    check_eq({nm, ":n_xact"},  32'(xq.size()), 32'(exp_idx.size()));
    sz = (xq.size() < exp_idx.size()) ? xq.size() : exp_idx.size();
    for (int i = 0; i < sz; i++) begin
      check_eq($sformatf("%s:ent%0d", nm, i), 32'(xq[i].ent), 32'(tbl[exp_idx[i]]));
      if (i > 0)
        check_eq($sformatf("%s:gap%0d", nm, i),
                 32'((xq[i].t_acc - xq[i-1].t_ret) >= GAP), 32'd1);
    end
    sz = xq.size();
    repeat (200) @(negedge clk);
    check_eq({nm, ":quiet"}, 32'(xq.size()), 32'(sz));
  endtask

  task automatic clear_err();
    for (int e = 0; e < NREG; e++) err_cnt[e] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int el;
    int k;
    clear_err();
    repeat (3) @(negedge clk);
    check_eq("rst:write",   32'(bus.write),    32'd0);
    check_eq("rst:busy",    32'(busy),         32'd0);
    check_eq("rst:done",    32'(done),         32'd0);
    check_eq("rst:fail",    32'(fail),         32'd0);
    check_eq("rst:reg_idx", 32'(reg_idx),      32'd0);
    check_eq("rst:subh",    32'(bus.SubAddrH), 32'd0);
    check_eq("rst:data",    32'(bus.Data),     32'd0);
    check_eq("rst:addr",    32'(bus.Addr),     32'h78);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Clean pass
    run_seq("clean");
    check_eq("clean:addr", 32'(bus.Addr), 32'h78);

    // Single NACK on entry 2, then OK
    clear_err();
    err_cnt[2] = 1;
    run_seq("nack2");

    // Entry 1 always NACKs: exhausts retries
    clear_err();
    err_cnt[1] = 99;
    run_seq("nack1");

    // Randomized NACK patterns
    for (int it = 0; it < 6; it++) begin
      for (int e = 0; e < NREG; e++) begin
        k = $urandom_range(0, 9);
        err_cnt[e] = (k < 6) ? 0 : (k < 8) ? 1 : (k == 8) ? 2 : 4;
      end
      run_seq($sformatf("rnd%0d", it));
    end
    clear_err();

    // Master never accepts
    never_drop = 1'b1;
    xq.delete();
    @(negedge clk) start = 1'b1;
    t0 = cyc;
    @(negedge clk) start = 1'b0;
    wait_end("tmo_acc", 6000);
    el = cyc - t0;
    check_eq("tmo_acc:fail",    32'(fail),    32'd1);
    check_eq("tmo_acc:reg_idx", 32'(reg_idx), 32'd0);
    check_eq("tmo_acc:write",   32'(bus.write), 32'd0);
    check_eq("tmo_acc:lat",     32'(el >= TMO && el <= TMO + 64), 32'd1);
    never_drop = 1'b0;
    do_reset();

    // Master accepts but never completes
    never_return = 1'b1;
    xq.delete();
    @(negedge clk) start = 1'b1;
    t0 = cyc;
    @(negedge clk) start = 1'b0;
    wait_end("tmo_cpl", 6000);
    el = cyc - t0;
    check_eq("tmo_cpl:fail",    32'(fail),    32'd1);
    check_eq("tmo_cpl:reg_idx", 32'(reg_idx), 32'd0);
    check_eq("tmo_cpl:n_xact",  32'(xq.size()), 32'd1);
    check_eq("tmo_cpl:lat",     32'(el >= TMO && el <= TMO + 64), 32'd1);
    never_return = 1'b0;
    do_reset();

    // Asynchronous reset during WAIT_DONE of entry 2
    xq.delete();
    pulse_start();
    k = 0;
    while (!(reg_idx == 8'd2 && !bus.ready) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("arst:reached", 32'(k < 2000), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst:write",   32'(bus.write),    32'd0);
    check_eq("arst:busy",    32'(busy),         32'd0);
    check_eq("arst:reg_idx", 32'(reg_idx),      32'd0);
    check_eq("arst:subl",    32'(bus.SubAddrL), 32'd0);
    check_eq("arst:done",    32'(done),         32'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    run_seq("after_rst");

    // Start held high and re-pulsed while busy: one sequence only
    xq.delete();
    @(negedge clk) start = 1'b1;
    repeat (150) @(negedge clk);
    start = 1'b0;
    @(negedge clk) start = 1'b1;
    wait_end("hold", 5000);
    check_eq("hold:done",   32'(done),      32'd1);
    check_eq("hold:n_xact", 32'(xq.size()), 32'(NREG));
    repeat (300) @(negedge clk);
    check_eq("hold:no_rerun", 32'(xq.size()), 32'(NREG));
    start = 1'b0;
    @(negedge clk);
    pulse_start();
    @(negedge clk);
    check_eq("rerun:done_clr", 32'(done), 32'd0);
    check_eq("rerun:busy",     32'(busy), 32'd1);
    wait_end("rerun", 5000);
    check_eq("rerun:done",   32'(done),      32'd1);
    check_eq("rerun:n_xact", 32'(xq.size()), 32'(2 * NREG));
    if (xq.size() == 2 * NREG)
      check_eq("rerun:ent0", 32'(xq[NREG].ent), 32'(tbl[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
